q_row_fetch: RTL and testbench

- Upstream feeder for the policy generator.
- On a start pulse, reads the nine Q entries for the current board state from the Q-table RAM and registers them as Q_1..Q_9 (18-bit each). Issue is pipelined, one read per cycle.
- Optionally masks occupied cells to the most-negative value so the max search never picks an illegal move.
- Presents the row with a valid/ack handshake.

---
 rtl/q_row_fetch_if.sv | 30 +++
 rtl/q_row_fetch.sv | 149 ++++++++++++++
 tb/tb_q_row_fetch.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_row_fetch_if.sv
// Handshake and Q-table RAM bundle for q_row_fetch.
// master = requester/consumer/RAM side, slave = the fetch engine.
interface q_row_fetch_if #(
    parameter int unsigned STATE_W = 15,
    parameter int unsigned Q_W     = 18
);
    logic               start;
    logic [STATE_W-1:0] state_idx;
    logic [17:0]        board;
    logic               busy;
    logic               ram_rd_en;
    logic [STATE_W+3:0] ram_addr;
    logic [Q_W-1:0]     ram_rdata;
    logic [Q_W-1:0]     q_1, q_2, q_3, q_4, q_5, q_6, q_7, q_8, q_9;
    logic               all_blocked;
    logic               q_valid;
    logic               q_ack;

    modport master (
        output start, state_idx, board, ram_rdata, q_ack,
        input  busy, ram_rd_en, ram_addr, all_blocked, q_valid,
        input  q_1, q_2, q_3, q_4, q_5, q_6, q_7, q_8, q_9
    );

    modport slave (
        input  start, state_idx, board, ram_rdata, q_ack,
        output busy, ram_rd_en, ram_addr, all_blocked, q_valid,
        output q_1, q_2, q_3, q_4, q_5, q_6, q_7, q_8, q_9
    );
endinterface

// File: rtl/q_row_fetch.sv
// Fetches the nine Q entries of one board state from the Q-table RAM, one read per cycle.
// Define QFETCH_MASK_EN to force occupied cells to the most-negative Q value.
module q_row_fetch #(
    parameter int unsigned STATE_W = 15,
    parameter int unsigned Q_W     = 18,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    q_row_fetch_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StValid} state_e;

    localparam logic [Q_W-1:0] QMin = {1'b1, {(Q_W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [STATE_W-1:0] idx_q, idx_d;
    logic [3:0]         act_q, act_d;
    logic               blk_q, blk_d;
    logic               trk_vld_q [RD_LAT];
    logic [3:0]         trk_act_q [RD_LAT];
    logic [Q_W-1:0]     q_q [9];
    logic [Q_W-1:0]     q_d [9];
    logic [8:0]         occ;
    logic               accept;
    logic               fetch;
    logic               cap_vld;
    logic [3:0]         cap_act;

    assign accept  = (state_q == StIdle) && bus_io.start;
    assign fetch   = (state_q == StFetch);
    assign cap_vld = trk_vld_q[RD_LAT-1];
    assign cap_act = trk_act_q[RD_LAT-1];

`ifdef QFETCH_MASK_EN
    logic [17:0] board_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            board_q <= '0;
        end else if (accept) begin
            board_q <= bus_io.board;
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            occ[i] = |board_q[2*i +: 2];
        end
    end
`else
    logic unused_board;
    assign unused_board = ^bus_io.board;
    assign occ          = '0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        blk_d   = blk_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    idx_d   = bus_io.state_idx;
                    act_d   = 4'd0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Counter stops at 8; slots 9..15 of the row are never addressed.
                if (act_q == 4'd8) begin
                    state_d = StDrain;
                end else begin
                    act_d = act_q + 4'd1;
                end
            end
            StDrain: begin
                if (cap_vld && (cap_act == 4'd8)) begin
                    state_d = StValid;
                    blk_d   = &occ;
                end
            end
            StValid: begin
                if (bus_io.q_ack) begin
                    state_d = StIdle;
                    blk_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            q_d[i] = q_q[i];
            if (cap_vld && (cap_act == 4'(i))) begin
                q_d[i] = occ[i] ? QMin : bus_io.ram_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            act_q   <= '0;
            blk_q   <= 1'b0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                trk_vld_q[i] <= 1'b0;
                trk_act_q[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            blk_q        <= blk_d;
            trk_vld_q[0] <= fetch;
            trk_act_q[0] <= act_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
                trk_act_q[i] <= trk_act_q[i-1];
            end
            for (int i = 0; i < 9; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.ram_rd_en   = fetch;
    assign bus_io.ram_addr    = fetch ? {idx_q, act_q} : '0;
    assign bus_io.q_valid     = (state_q == StValid);
    assign bus_io.all_blocked = blk_q;
    assign bus_io.q_1         = q_q[0];
    assign bus_io.q_2         = q_q[1];
    assign bus_io.q_3         = q_q[2];
    assign bus_io.q_4         = q_q[3];
    assign bus_io.q_5         = q_q[4];
    assign bus_io.q_6         = q_q[5];
    assign bus_io.q_7         = q_q[6];
    assign bus_io.q_8         = q_q[7];
    assign bus_io.q_9         = q_q[8];

endmodule

// File: tb/tb_q_row_fetch.sv
// Directed bench for q_row_fetch: one instance at RD_LAT=1, one at RD_LAT=3.
// Expectations follow QFETCH_MASK_EN when it is defined for the build.
module tb_q_row_fetch;

    localparam logic [17:0] QMin = 18'h20000;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    q_row_fetch_if #(.STATE_W(15), .Q_W(18)) if1 ();
    q_row_fetch_if #(.STATE_W(15), .Q_W(18)) if2 ();

    q_row_fetch #(.STATE_W(15), .Q_W(18), .RD_LAT(1)) dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(if1.slave)
    );

    q_row_fetch #(.STATE_W(15), .Q_W(18), .RD_LAT(3)) dut2 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row 5 holds k*10, row 7 holds 1000+k*10.
    function automatic logic [17:0] ram1(input logic [18:0] a);
        logic [17:0] v;
        v = 18'(a[3:0]) * 18'd10;
        if (a[18:4] == 15'd7) v = v + 18'd1000;
        return v;
    endfunction

    function automatic logic [17:0] ram2(input logic [18:0] a);
        return a[17:0] ^ 18'h2A5A5;
    endfunction

    always @(posedge clk) begin
        if (if1.ram_rd_en) if1.ram_rdata <= ram1(if1.ram_addr);
        else               if1.ram_rdata <= 18'h3FFFF;
    end

    logic [17:0] d2 [3];
    always @(posedge clk) begin
        d2[0] <= if2.ram_rd_en ? ram2(if2.ram_addr) : 18'h3FFFF;
        d2[1] <= d2[0];
        d2[2] <= d2[1];
    end
    assign if2.ram_rdata = d2[2];

    logic [17:0] q1 [9];
    logic [17:0] q2 [9];
    always_comb begin
        q1[0] = if1.q_1; q1[1] = if1.q_2; q1[2] = if1.q_3;
        q1[3] = if1.q_4; q1[4] = if1.q_5; q1[5] = if1.q_6;
        q1[6] = if1.q_7; q1[7] = if1.q_8; q1[8] = if1.q_9;
        q2[0] = if2.q_1; q2[1] = if2.q_2; q2[2] = if2.q_3;
        q2[3] = if2.q_4; q2[4] = if2.q_5; q2[5] = if2.q_6;
        q2[6] = if2.q_7; q2[7] = if2.q_8; q2[8] = if2.q_9;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance 1 in cycle C0 and advance into C1.
    task automatic start1(input logic [14:0] s, input logic [17:0] b);
        if1.start     = 1'b1;
        if1.state_idx = s;
        if1.board     = b;
        step();
        if1.start = 1'b0;
    endtask

    // Step until q_valid on instance 1; ok=0 if the budget runs out.
    task automatic wait_valid1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if1.q_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic ack1();
        if1.q_ack = 1'b1;
        step();
        if1.q_ack = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({if1.busy, if1.ram_rd_en, if1.q_valid, if1.all_blocked} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {if1.busy, if1.ram_rd_en, if1.q_valid, if1.all_blocked});
        end
        n_tests++;
        if (if1.ram_addr !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0", if1.ram_addr);
        end
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (q1[k] !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_q%0d: got %h want 0", k + 1, q1[k]);
            end
        end
    endtask

    task automatic test_basic();
        start1(15'd5, 18'd0);
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (if1.ram_rd_en !== 1'b1 || if1.ram_addr !== {15'd5, 4'(k)}) begin
                n_fail++;
                $display("FAIL basic_addr C%0d: got en=%b addr=%h want en=1 addr=%h",
                         k + 1, if1.ram_rd_en, if1.ram_addr, {15'd5, 4'(k)});
            end
            step();
        end
        n_tests++;
        if (if1.q_valid !== 1'b0 || if1.ram_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_c10: got valid=%b en=%b want 0 0", if1.q_valid, if1.ram_rd_en);
        end
        step();
        n_tests++;
        if (if1.q_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid_c11: got %b want 1", if1.q_valid);
        end
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (q1[k] !== 18'(k * 10)) begin
                n_fail++;
                $display("FAIL basic_q%0d: got %0d want %0d", k + 1, q1[k], k * 10);
            end
        end
        n_tests++;
        if (if1.all_blocked !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_blocked: got %b want 0", if1.all_blocked);
        end
        ack1();
    endtask

    task automatic test_mask();
        bit          ok;
        logic [17:0] exp;
        start1(15'd5, 18'b00_00_00_00_10_00_00_00_01);
        wait_valid1(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mask_timeout: got no q_valid want q_valid");
        end
        for (int k = 0; k < 9; k++) begin
            exp = 18'(k * 10);
`ifdef QFETCH_MASK_EN
            if (k == 0 || k == 4) exp = QMin;
`endif
            n_tests++;
            if (q1[k] !== exp) begin
                n_fail++;
                $display("FAIL mask_q%0d: got %h want %h", k + 1, q1[k], exp);
            end
        end
        ack1();
        start1(15'd5, 18'b01_10_11_01_10_01_10_01_10);
        wait_valid1(ok);
        for (int k = 0; k < 9; k++) begin
`ifdef QFETCH_MASK_EN
            exp = QMin;
`else
            exp = 18'(k * 10);
`endif
            n_tests++;
            if (q1[k] !== exp) begin
                n_fail++;
                $display("FAIL full_q%0d: got %h want %h", k + 1, q1[k], exp);
            end
        end
        n_tests++;
`ifdef QFETCH_MASK_EN
        if (if1.all_blocked !== 1'b1) begin
            n_fail++;
            $display("FAIL full_blocked: got %b want 1", if1.all_blocked);
        end
`else
        if (if1.all_blocked !== 1'b0) begin
            n_fail++;
            $display("FAIL full_blocked: got %b want 0", if1.all_blocked);
        end
`endif
        ack1();
        n_tests++;
        if (if1.all_blocked !== 1'b0) begin
            n_fail++;
            $display("FAIL blocked_clear: got %b want 0", if1.all_blocked);
        end
    endtask

    task automatic test_hold();
        bit ok;
        start1(15'd5, 18'd0);
        wait_valid1(ok);
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if (if1.q_valid !== 1'b1 || q1[0] !== 18'd0 || q1[3] !== 18'd30 ||
                q1[8] !== 18'd80) begin
                n_fail++;
                $display("FAIL hold_c%0d: got valid=%b q1=%0d q4=%0d q9=%0d want 1 0 30 80",
                         c, if1.q_valid, q1[0], q1[3], q1[8]);
            end
            step();
        end
        if1.start     = 1'b1;
        if1.state_idx = 15'd7;
        if1.q_ack     = 1'b1;
        step();
        if1.start = 1'b0;
        if1.q_ack = 1'b0;
        n_tests++;
        if (if1.q_valid !== 1'b0 || if1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_after_ack: got valid=%b busy=%b want 0 0", if1.q_valid, if1.busy);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (if1.busy !== 1'b0 || if1.ram_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_start_ignored: got busy=%b en=%b want 0 0",
                         if1.busy, if1.ram_rd_en);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        start1(15'd5, 18'd0);
        for (int k = 0; k < 9; k++) begin
            if (k == 3) begin
                if1.start     = 1'b1;
                if1.state_idx = 15'd7;
            end else begin
                if1.start = 1'b0;
            end
            n_tests++;
            if (if1.ram_addr !== {15'd5, 4'(k)}) begin
                n_fail++;
                $display("FAIL busy_addr C%0d: got %h want %h", k + 1, if1.ram_addr,
                         {15'd5, 4'(k)});
            end
            step();
        end
        if1.start = 1'b0;
        wait_valid1(ok);
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (q1[k] !== 18'(k * 10)) begin
                n_fail++;
                $display("FAIL busy_q%0d: got %0d want %0d", k + 1, q1[k], k * 10);
            end
        end
        ack1();
        step();
        n_tests++;
        if (if1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_not_queued: got busy=%b want 0", if1.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start1(15'd5, 18'd0);
        for (int c = 1; c < 6; c++) step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if1.busy, if1.ram_rd_en, if1.q_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b want 000", {if1.busy, if1.ram_rd_en, if1.q_valid});
        end
        n_tests++;
        if (q1[3] !== 18'd0 || q1[0] !== 18'd0) begin
            n_fail++;
            $display("FAIL midrst_q: got q1=%0d q4=%0d want 0 0", q1[0], q1[3]);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step();
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (q1[k] !== 18'd0) begin
                n_fail++;
                $display("FAIL midrst_late_q%0d: got %h want 0", k + 1, q1[k]);
            end
        end
        start1(15'd7, 18'd0);
        wait_valid1(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_restart: got no q_valid want q_valid");
        end
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (q1[k] !== 18'(1000 + k * 10)) begin
                n_fail++;
                $display("FAIL midrst_q%0d: got %0d want %0d", k + 1, q1[k], 1000 + k * 10);
            end
        end
        ack1();
    endtask

    task automatic test_latency();
        logic [14:0] s;
        s             = 15'h1ABC;
        if2.start     = 1'b1;
        if2.state_idx = s;
        step();
        if2.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 9) begin
                n_tests++;
                if (if2.ram_addr !== {s, 4'(c - 1)}) begin
                    n_fail++;
                    $display("FAIL lat_addr C%0d: got %h want %h", c, if2.ram_addr, {s, 4'(c - 1)});
                end
            end
            n_tests++;
            if (if2.q_valid !== (c == 13)) begin
                n_fail++;
                $display("FAIL lat_valid C%0d: got %b want %b", c, if2.q_valid, c == 13);
            end
            if (c < 13) step();
        end
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (q2[k] !== ram2({s, 4'(k)})) begin
                n_fail++;
                $display("FAIL lat_q%0d: got %h want %h", k + 1, q2[k], ram2({s, 4'(k)}));
            end
        end
        if2.q_ack = 1'b1;
        step();
        if2.q_ack = 1'b0;
        n_tests++;
        if (if2.q_valid !== 1'b0 || if2.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_ack: got valid=%b busy=%b want 0 0", if2.q_valid, if2.busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b1;
        if1.start     = 1'b0;
        if1.state_idx = '0;
        if1.board     = '0;
        if1.q_ack     = 1'b0;
        if2.start     = 1'b0;
        if2.state_idx = '0;
        if2.board     = '0;
        if2.q_ack     = 1'b0;
        #2 rst_n = 1'b0;
        step();
        test_reset();
        step();
        rst_n = 1'b1;
        step();
        test_basic();
        test_mask();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
